imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Writer side of the instruction memory that the fetch unit reads from.
- Receives a byte stream from the UART receiver and packs it, little-endian, into 32-bit instruction words.
- Writes each word sequentially into the program memory write port, starting at word address 0.
- Holds the CPU in reset while loading and reports completion or error to the top level.

Parameters:
- ADDR_W, 14, instruction memory word-address width (matches the 14-bit fetch address).
- WORD_LIMIT, 16384, maximum words per load; load ends automatically when this count is reached.
- IDLE_CYCLES, 1000000, clock cycles with no byte that end an armed load (timeout).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data valid this cycle.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  high while loading; the top level ORs it into the CPU reset.
- busy  out  1  high in LOAD state.
- done  out  1  sticky: last load finished cleanly.
- error  out  1  sticky: last load ended with a partial word.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; byte index=0; word_count=0.
- Reset values of outputs: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, error=0; timeout counter=0.
- Reset asserted mid-load aborts the load. Memory contents already written are left as is; no further write is issued.

States:
- IDLE:
  - start=1 -> LOAD next cycle.
  - On entry to LOAD: word_count=0, byte index=0, done=0, error=0, timeout counter cleared and disarmed; cpu_hold=1, busy=1.
  - rx_valid in IDLE is ignored.
- LOAD:
  - Each rx_valid byte goes to lane [8*idx+7:8*idx] of the assembly register; idx increments mod 4.
  - The first byte accepted becomes bits [7:0].
  - The first accepted byte arms the timeout.
  - When the 4th byte is accepted in cycle N, in cycle N+1: imem_we=1, imem_wdata=the assembled word, imem_addr=word_count[ADDR_W-1:0]. word_count increments at the end of cycle N+1.
  - imem_we is high for exactly one cycle per word.
  - A byte accepted in cycle N+1 is legal and starts the next word.
  - start in LOAD is ignored.
- FINISH: entered from LOAD on either end condition below. One cycle with cpu_hold and busy dropped, then IDLE. done and error hold their values until the next start or reset.

End conditions (checked in LOAD):
- Word limit: the write that makes word_count==WORD_LIMIT -> FINISH after that write cycle, done=1. Bytes arriving after that are ignored.
- Timeout:
  - While armed, the counter increments each cycle without rx_valid and clears on rx_valid.
  - Counter reaching IDLE_CYCLES-1 with no byte -> FINISH.
  - idx==0 at that point: done=1, error=0.
  - idx!=0: partial word discarded (never written), error=1, done=0.
- Unarmed LOAD (no byte yet received) waits indefinitely with cpu_hold=1.
- rx_valid in the same cycle the timeout fires: the byte wins. It is accepted, the counter clears, and there is no timeout.

Arithmetic and widths:
- imem_addr wraps never; the WORD_LIMIT check precedes any overflow.
- WORD_LIMIT must be at most 2^ADDR_W.
- word_count saturates at WORD_LIMIT.

Test Plan:
- Reset, start, then bytes 0x13,0x00,0x00,0x00 then 0xAA,0xBB,0xCC,0xDD, then silence -> writes 0x00000013 @0 and 0xDDCCBBAA @1, each with a one-cycle imem_we; after IDLE_CYCLES (bench uses 20): done=1, error=0, word_count=2, cpu_hold=0.
- WORD_LIMIT=3, 16 bytes sent back-to-back (rx_valid every cycle) -> exactly 3 writes @0..2, done=1 right after the 3rd write, remaining 4 bytes produce no write, word_count=3.
- Start, then 6 bytes, then silence -> one write @0, partial 2 bytes never written, error=1, done=0, word_count=1.
- start pulsed again mid-load and rx_valid pulsed in IDLE -> no restart, no write from the IDLE bytes; addresses continue sequentially.
- Reset asserted after 2 words plus 1 byte -> next cycle all outputs at reset values, no imem_we; new start rewrites from address 0 with word_count=0.
- Byte arriving on the exact cycle the counter hits IDLE_CYCLES-1 -> accepted, load continues; timeout fires only after a full new silent interval.

Source files
------------

// File: rtl/imem_uart_loader.sv
// Packs a UART byte stream little-endian into 32-bit words and writes them
// sequentially into instruction memory while holding the CPU in reset.
module imem_uart_loader #(
  parameter int ADDR_W      = 14,
  parameter int WORD_LIMIT  = 16384,
  parameter int IDLE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int TW = $clog2(IDLE_CYCLES + 1);
  localparam logic [TW-1:0]   T_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0]   T_ONE  = TW'(1);
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W + 1)'(WORD_LIMIT);
  localparam logic [ADDR_W:0] WC_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [31:0]     assembly;
  logic            armed;
  logic [TW-1:0]   tcnt;
  logic [ADDR_W:0] wc_next;
  logic            limit_hit;

  // The write cycle that brings word_count up to the limit ends the load.
  assign wc_next   = word_count + WC_ONE;
  assign limit_hit = imem_we && (wc_next == LIMIT);

  // rx_valid is a one-cycle strobe with no ready/backpressure: a byte is
  // taken in LOAD whenever rx_valid is high, and dropped in any other state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      assembly   <= 32'd0;
      armed      <= 1'b0;
      tcnt       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) word_count <= wc_next;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
            idx        <= 2'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            armed      <= 1'b0;
            tcnt       <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (limit_hit) begin
            state    <= FINISH;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end else if (rx_valid) begin
            armed                    <= 1'b1;
            tcnt                     <= '0;
            idx                      <= idx + 2'd1;
            assembly[{idx, 3'b000} +: 8] <= rx_data;
            if (idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {rx_data, assembly[23:0]};
              imem_addr  <= word_count[ADDR_W-1:0];
            end
          end else if (armed) begin
            if (tcnt == T_LAST) begin
              // A partial word is dropped and flagged rather than written.
              state    <= FINISH;
              done     <= (idx == 2'd0);
              error    <= (idx != 2'd0);
              idx      <= 2'd0;
              cpu_hold <= 1'b0;
              busy     <= 1'b0;
            end else begin
              tcnt <= tcnt + T_ONE;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: small WORD_LIMIT and IDLE_CYCLES so
// the word-limit and timeout paths are reached in a few hundred cycles.
module tb_imem_uart_loader;

  localparam int ADDR_W      = 14;
  localparam int WORD_LIMIT  = 3;
  localparam int IDLE_CYCLES = 20;
  localparam int W           = ADDR_W + 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int          total = 0;
  int          bad   = 0;
  logic        prev_we = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  imem_uart_loader #(
    .ADDR_W(ADDR_W), .WORD_LIMIT(WORD_LIMIT), .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .word_count(word_count)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the head of exp_q and last one cycle.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      total++;
      assert (prev_we === 1'b0) else begin
        bad++;
        $error("FAIL we_pulse: got imem_we high 2 cycles expected 1");
      end
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write: got addr=%0d data=%h expected no write", imem_addr, imem_wdata);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("write", 64'({imem_addr, imem_wdata}), 64'(exp_w));
        check("write_hold", 64'(cpu_hold), 64'd1);
      end
    end
    prev_we = imem_we;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic silence(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_word(input int addr, input logic [31:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(imem_we),    64'd0);
    check({tag, "_addr"},  64'(imem_addr),  64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_hold"},  64'(cpu_hold),   64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_done"},  64'(done),       64'd0);
    check({tag, "_error"}, 64'(error),      64'd0);
    check({tag, "_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    silence(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Two words then silence: clean timeout
    pulse_start();
    check("s1_hold", 64'(cpu_hold), 64'd1);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_count0", 64'(word_count), 64'd0);
    expect_word(0, 32'h0000_0013);
    expect_word(1, 32'hDDCC_BBAA);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    silence(IDLE_CYCLES - 1);
    check("s1_not_yet", 64'(done), 64'd0);
    check("s1_busy_wait", 64'(busy), 64'd1);
    silence(1);
    check("s1_done", 64'(done), 64'd1);
    check("s1_error", 64'(error), 64'd0);
    check("s1_hold_drop", 64'(cpu_hold), 64'd0);
    check("s1_busy_drop", 64'(busy), 64'd0);
    check("s1_count", 64'(word_count), 64'd2);
    check("s1_drained", 64'(exp_q.size()), 64'd0);
    silence(1);
    check("s1_done_sticky", 64'(done), 64'd1);
    silence(1);

    // Word limit with back-to-back bytes
    pulse_start();
    check("s2_done_clear", 64'(done), 64'd0);
    expect_word(0, 32'h1312_1110);
    expect_word(1, 32'h1716_1514);
    expect_word(2, 32'h1B1A_1918);
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h10 + i));
      if (i == 11) check("s2_before_limit", 64'(done), 64'd0);
      if (i == 12) begin
        check("s2_limit_done", 64'(done), 64'd1);
        check("s2_limit_busy", 64'(busy), 64'd0);
      end
    end
    silence(2);
    check("s2_count", 64'(word_count), 64'd3);
    check("s2_error", 64'(error), 64'd0);
    check("s2_drained", 64'(exp_q.size()), 64'd0);

    // Partial word at timeout
    pulse_start();
    check("s3_done_clear", 64'(done), 64'd0);
    expect_word(0, 32'h0403_0201);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
    silence(IDLE_CYCLES - 1);
    check("s3_not_yet", 64'(error), 64'd0);
    silence(1);
    check("s3_error", 64'(error), 64'd1);
    check("s3_done", 64'(done), 64'd0);
    check("s3_count", 64'(word_count), 64'd1);
    check("s3_drained", 64'(exp_q.size()), 64'd0);
    silence(2);

    // Bytes in IDLE ignored; start during LOAD ignored
    send(8'hEE); send(8'hEF); send(8'hF0); send(8'hF1);
    check("s4_idle_count", 64'(word_count), 64'd1);
    check("s4_idle_error", 64'(error), 64'd1);
    check("s4_idle_busy", 64'(busy), 64'd0);
    pulse_start();
    check("s4_error_clear", 64'(error), 64'd0);
    expect_word(0, 32'h2423_2221);
    expect_word(1, 32'h3433_3231);
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    start = 1'b1;
    send(8'h31);
    start = 1'b0;
    send(8'h32); send(8'h33); send(8'h34);
    silence(1);
    check("s4_count_mid", 64'(word_count), 64'd2);
    check("s4_busy_mid", 64'(busy), 64'd1);
    silence(IDLE_CYCLES - 1);
    check("s4_done", 64'(done), 64'd1);
    check("s4_count", 64'(word_count), 64'd2);
    check("s4_drained", 64'(exp_q.size()), 64'd0);
    silence(2);

    // Reset after two words plus one byte
    pulse_start();
    expect_word(0, 32'h4443_4241);
    expect_word(1, 32'h4847_4645);
    for (int i = 0; i < 9; i++) send(8'(8'h41 + i));
    reset = 1'b1;
    tick();
    check_reset_outputs("s5_rst");
    reset = 1'b0;
    silence(2);
    check("s5_drained", 64'(exp_q.size()), 64'd0);
    check("s5_idle_hold", 64'(cpu_hold), 64'd0);
    pulse_start();
    check("s5_count0", 64'(word_count), 64'd0);
    expect_word(0, 32'h5453_5251);
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    silence(1);
    check("s5_count1", 64'(word_count), 64'd1);
    silence(IDLE_CYCLES - 1);
    check("s5_done", 64'(done), 64'd1);
    check("s5_drained2", 64'(exp_q.size()), 64'd0);
    silence(2);

    // Byte arriving on the last silent cycle beats the timeout
    pulse_start();
    expect_word(0, 32'h6463_6261);
    expect_word(1, 32'h6867_6665);
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    silence(IDLE_CYCLES - 1);
    check("s6_edge_busy", 64'(busy), 64'd1);
    send(8'h65);
    check("s6_byte_won", 64'(busy), 64'd1);
    check("s6_byte_won_done", 64'(done), 64'd0);
    silence(IDLE_CYCLES - 1);
    check("s6_interval_restart", 64'(busy), 64'd1);
    send(8'h66); send(8'h67); send(8'h68);
    silence(IDLE_CYCLES - 1);
    check("s6_final_wait", 64'(busy), 64'd1);
    silence(1);
    check("s6_done", 64'(done), 64'd1);
    check("s6_error", 64'(error), 64'd0);
    check("s6_count", 64'(word_count), 64'd2);
    check("s6_drained", 64'(exp_q.size()), 64'd0);
    silence(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
